// File: rtl/avg_datapath_pkg.sv
// Shared control encodings for the averaging datapath: register codes and ULA opcodes.
// The control-code generator drives these same values on tx/ty/tz/tula.
package avg_datapath_pkg;

  localparam int unsigned CodeWidth = 4;

  typedef enum logic [CodeWidth-1:0] {
    RegClear  = 4'd0,
    RegLoad   = 4'd1,
    RegHold   = 4'd2,
    RegShiftR = 4'd3
  } reg_code_e;

  typedef enum logic [CodeWidth-1:0] {
    UlaAdd   = 4'd0,
    UlaSub   = 4'd1,
    UlaAnd   = 4'd2,
    UlaOr    = 4'd3,
    UlaXor   = 4'd4,
    UlaPassX = 4'd5
  } ula_op_e;

endpackage

// File: rtl/avg_datapath_reg_unit.sv
// One datapath register driven by a 4-bit control code: clear, load, hold or shift right.
// Unassigned codes hold; shift_in supplies the new MSB on a right shift.
module avg_datapath_reg_unit
  import avg_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CodeWidth-1:0] code,
  input  logic [WIDTH-1:0]     d,
  input  logic                 shift_in,
  output logic [WIDTH-1:0]     q
);

  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q;
    case (code)
      RegClear:  q_d = '0;
      RegLoad:   q_d = d;
      RegShiftR: q_d = {shift_in, q[WIDTH-1:1]};
      default:   q_d = q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/avg_datapath.sv
// Register-level datapath: X latches data_in, Y accumulates the ULA result, Z holds the output.
// Y's carry rotates back in on a right shift so (A+B)/2 stays exact after an ADD overflow.
module avg_datapath
  import avg_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [CodeWidth-1:0] tx,
  input  logic [CodeWidth-1:0] ty,
  input  logic [CodeWidth-1:0] tz,
  input  logic [CodeWidth-1:0] tula,
  output logic [WIDTH-1:0]     x_q,
  output logic [WIDTH-1:0]     y_q,
  output logic [WIDTH-1:0]     z_q,
  output logic                 carry_q,
  output logic                 z_valid
);

  logic [WIDTH:0] ula_res;
  logic           carry_d;

  always_comb begin
    ula_res = '0;
    case (tula)
      UlaAdd:   ula_res = {1'b0, x_q} + {1'b0, y_q};
      UlaSub:   ula_res = {1'b0, x_q} - {1'b0, y_q};
      UlaAnd:   ula_res = {1'b0, x_q & y_q};
      UlaOr:    ula_res = {1'b0, x_q | y_q};
      UlaXor:   ula_res = {1'b0, x_q ^ y_q};
      UlaPassX: ula_res = {1'b0, x_q};
      default:  ula_res = '0;
    endcase
  end

  avg_datapath_reg_unit #(.WIDTH(WIDTH)) u_reg_x (
    .clock    (clock),
    .reset_n  (reset_n),
    .code     (tx),
    .d        (data_in),
    .shift_in (1'b0),
    .q        (x_q)
  );

  avg_datapath_reg_unit #(.WIDTH(WIDTH)) u_reg_y (
    .clock    (clock),
    .reset_n  (reset_n),
    .code     (ty),
    .d        (ula_res[WIDTH-1:0]),
    .shift_in (carry_q),
    .q        (y_q)
  );

  avg_datapath_reg_unit #(.WIDTH(WIDTH)) u_reg_z (
    .clock    (clock),
    .reset_n  (reset_n),
    .code     (tz),
    .d        (y_q),
    .shift_in (1'b0),
    .q        (z_q)
  );

  // Carry follows Y: captured on load, consumed by the shift, cleared with Y.
  always_comb begin
    carry_d = carry_q;
    case (ty)
      RegClear:  carry_d = 1'b0;
      RegLoad:   carry_d = ula_res[WIDTH];
      RegShiftR: carry_d = 1'b0;
      default:   carry_d = carry_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_q <= 1'b0;
      z_valid <= 1'b0;
    end else begin
      carry_q <= carry_d;
      z_valid <= (tz == RegLoad);
    end
  end

endmodule

// File: tb/tb_avg_datapath.sv
// Directed self-checking bench for avg_datapath using the 6-step averaging control sequence.
module tb_avg_datapath;
  import avg_datapath_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       tx, ty, tz, tula;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic             carry_q, z_valid;

  int checks = 0;
  int errors = 0;

  // Snapshots taken by run_avg after each relevant edge.
  logic [WIDTH-1:0] y_add, y_shr, z_out;
  logic             c_add, c_shr, zv_out, zv_after;

  avg_datapath #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data_in (data_in),
    .tx      (tx),
    .ty      (ty),
    .tz      (tz),
    .tula    (tula),
    .x_q     (x_q),
    .y_q     (y_q),
    .z_q     (z_q),
    .carry_q (carry_q),
    .z_valid (z_valid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_codes();
    tx = RegHold; ty = RegHold; tz = RegHold; tula = UlaAdd;
  endtask

  // Phase p of the standard sequence: LOAD A, Y=A, LOAD B, ADD, SHIFTR, Z load.
  task automatic drive_phase(input int p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    idle_codes();
    case (p)
      0: begin tx = RegLoad; data_in = a; end
      1: begin ty = RegLoad; tula = UlaPassX; end
      2: begin tx = RegLoad; data_in = b; end
      3: begin ty = RegLoad; tula = UlaAdd; end
      4: ty = RegShiftR;
      default: tz = RegLoad;
    endcase
  endtask

  task automatic run_avg(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int p = 0; p < 6; p++) begin
      drive_phase(p, a, b);
      step();
      if (p == 3) begin y_add = y_q; c_add = carry_q; end
      if (p == 4) begin y_shr = y_q; c_shr = carry_q; end
      if (p == 5) begin z_out = z_q; zv_out = z_valid; end
    end
    idle_codes();
    step();
    zv_after = z_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_in = '0;
    idle_codes();
    #3;
    checks++;
    if ({x_q, y_q, z_q, carry_q, z_valid} !== '0) begin
      errors++;
      $display("FAIL reset_state: x=%0d y=%0d z=%0d c=%0b zv=%0b, need all 0",
               x_q, y_q, z_q, carry_q, z_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_average();
    run_avg(8'd10, 8'd20);
    checks++;
    if (y_add !== 8'd30) begin errors++; $display("FAIL avg_sum: y=%0d need 30", y_add); end
    checks++;
    if (y_shr !== 8'd15) begin errors++; $display("FAIL avg_shift: y=%0d need 15", y_shr); end
    checks++;
    if (z_out !== 8'd15 || zv_out !== 1'b1) begin
      errors++;
      $display("FAIL avg_z: z=%0d zv=%0b need 15/1", z_out, zv_out);
    end
    checks++;
    if (zv_after !== 1'b0) begin
      errors++;
      $display("FAIL avg_zv_pulse: zv=%0b need 0", zv_after);
    end
  endtask

  task automatic test_overflow();
    run_avg(8'd255, 8'd255);
    checks++;
    if (y_add !== 8'd254 || c_add !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sum: y=%0d c=%0b need 254/1", y_add, c_add);
    end
    checks++;
    if (y_shr !== 8'd255 || c_shr !== 1'b0) begin
      errors++;
      $display("FAIL ovf_shift: y=%0d c=%0b need 255/0", y_shr, c_shr);
    end
    checks++;
    if (z_out !== 8'd255) begin errors++; $display("FAIL ovf_z: z=%0d need 255", z_out); end
  endtask

  task automatic test_odd_sum();
    run_avg(8'd3, 8'd4);
    checks++;
    if (z_out !== 8'd3) begin errors++; $display("FAIL odd_z: z=%0d need 3", z_out); end
    run_avg(8'd0, 8'd0);
    checks++;
    if (z_out !== 8'd0) begin errors++; $display("FAIL zero_z: z=%0d need 0", z_out); end
  endtask

  task automatic test_hold_codes();
    idle_codes(); tx = RegLoad; data_in = 8'd9;
    step();
    idle_codes(); tx = RegLoad; data_in = 8'd8; ty = RegLoad; tula = UlaPassX;
    step();
    idle_codes(); tx = RegLoad; data_in = 8'd7; ty = RegLoad; tula = UlaPassX; tz = RegLoad;
    step();
    checks++;
    if (x_q !== 8'd7 || y_q !== 8'd8 || z_q !== 8'd9 || z_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_setup: x=%0d y=%0d z=%0d zv=%0b need 7/8/9/1", x_q, y_q, z_q, z_valid);
    end
    tx = 4'd9; ty = 4'd9; tz = 4'd9; tula = UlaAdd; data_in = 8'd100;
    step();
    checks++;
    if (x_q !== 8'd7 || y_q !== 8'd8 || z_q !== 8'd9 || z_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_code9: x=%0d y=%0d z=%0d zv=%0b need 7/8/9/0", x_q, y_q, z_q, z_valid);
    end
    idle_codes();
  endtask

  task automatic test_ula_ops();
    idle_codes(); tx = RegLoad; data_in = 8'd7;
    step();
    idle_codes(); tx = RegLoad; data_in = 8'd5; ty = RegLoad; tula = UlaPassX;
    step();
    idle_codes(); ty = RegLoad; tula = UlaSub;
    step();
    checks++;
    if (y_q !== 8'd254 || carry_q !== 1'b1) begin
      errors++;
      $display("FAIL ula_sub: y=%0d c=%0b need 254/1", y_q, carry_q);
    end
    idle_codes(); ty = RegLoad; tula = 4'd6;
    step();
    checks++;
    if (y_q !== 8'd0 || carry_q !== 1'b0) begin
      errors++;
      $display("FAIL ula_op6: y=%0d c=%0b need 0/0", y_q, carry_q);
    end
    idle_codes();
  endtask

  task automatic test_mid_reset();
    for (int p = 0; p < 4; p++) begin
      drive_phase(p, 8'd10, 8'd20);
      step();
    end
    checks++;
    if (y_q !== 8'd30) begin errors++; $display("FAIL midrst_pre: y=%0d need 30", y_q); end
    drive_phase(4, 8'd10, 8'd20);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({x_q, y_q, z_q, carry_q, z_valid} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: x=%0d y=%0d z=%0d c=%0b zv=%0b need all 0",
               x_q, y_q, z_q, carry_q, z_valid);
    end
    idle_codes();
    @(negedge clock);
    reset_n = 1'b1;
    run_avg(8'd10, 8'd20);
    checks++;
    if (z_out !== 8'd15 || zv_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rerun: z=%0d zv=%0b need 15/1", z_out, zv_out);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_overflow();
    test_odd_sum();
    test_hold_codes();
    test_ula_ops();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
